bh1750_i2c_target: RTL and testbench

I2C target (responder) that emulates a BH1750 ambient-light sensor on the shared two-wire bus. It answers the team's I2C master in simulation and in loopback bring-up. It accepts single-byte opcode writes and returns a 16-bit measurement on reads. It sits on the bus side opposite the master, with `i_data` fed by a stimulus register or a light-model block.

---
 rtl/bh1750_i2c_target.sv | 252 +++++++++++++++++++++++++
 tb/tb_bh1750_i2c_target.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bh1750_i2c_target.sv
// I2C target emulating a BH1750 light sensor: single-byte opcode writes, 16-bit reads.
// SCL is only sampled; SDA is open-drain (driven low or released, never driven high).
module bh1750_i2c_target #(
  parameter logic [6:0]  p_ADDRESS = 7'b010_0011,
  parameter int unsigned p_SYNC    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  inout  wire         io_scl,
  inout  wire         io_sda,
  input  logic [15:0] i_data,
  output logic [7:0]  o_opcode,
  output logic        o_opcode_valid,
  output logic        o_read_done,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_RX_BYTE,
    S_RX_ACK,
    S_TX_BYTE,
    S_TX_ACK,
    S_IGNORE
  } state_t;

  // Bus front end: synchronizers, previous-level register, registered edge pulses.
  logic [p_SYNC-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s;
  logic scl_q, sda_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_s = scl_sync[p_SYNC-1];
  assign sda_s = sda_sync[p_SYNC-1];

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses <= so every register sees the pre-edge values of the others.
    if (i_rst) begin
      scl_sync  <= '1;
      sda_sync  <= '1;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_sync  <= {scl_sync[p_SYNC-2:0], io_scl};
      sda_sync  <= {sda_sync[p_SYNC-2:0], io_sda};
      scl_q     <= scl_s;
      sda_q     <= sda_s;
      scl_rise  <= scl_s & ~scl_q;
      scl_fall  <= ~scl_s & scl_q;
      start_det <= scl_s & scl_q & ~sda_s & sda_q;
      stop_det  <= scl_s & scl_q & sda_s & ~sda_q;
    end
  end

  // Protocol state. sda_q is the SDA level aligned with the edge pulses.
  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic       phase, phase_n;
  logic       rw, rw_n;
  logic [7:0] rx_shift, rx_shift_n;
  logic [7:0] tx_shift, tx_shift_n;
  logic [7:0] tx_lo, tx_lo_n;
  logic       tx_next_lo, tx_next_lo_n;
  logic       sda_low, sda_low_n;
  logic [7:0] opcode_n;
  logic       opcode_valid_n, read_done_n, busy_n;

  assign io_scl = 1'bz;
  assign io_sda = sda_low ? 1'b0 : 1'bz;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_n        = state;
    bit_cnt_n      = bit_cnt;
    phase_n        = phase;
    rw_n           = rw;
    rx_shift_n     = rx_shift;
    tx_shift_n     = tx_shift;
    tx_lo_n        = tx_lo;
    tx_next_lo_n   = tx_next_lo;
    sda_low_n      = sda_low;
    opcode_n       = o_opcode;
    opcode_valid_n = 1'b0;
    read_done_n    = 1'b0;
    busy_n         = o_busy;

    if (stop_det) begin
      state_n   = S_IDLE;
      bit_cnt_n = 3'd0;
      phase_n   = 1'b0;
      sda_low_n = 1'b0;
      busy_n    = 1'b0;
    end else if (start_det) begin
      state_n   = S_ADDR;
      bit_cnt_n = 3'd0;
      phase_n   = 1'b0;
      sda_low_n = 1'b0;
      busy_n    = 1'b0;
    end else begin
      case (state)
        S_IDLE: sda_low_n = 1'b0;

        S_ADDR: begin
          if (scl_rise) begin
            rx_shift_n = {rx_shift[6:0], sda_q};
            bit_cnt_n  = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx_shift_n[7:1] == p_ADDRESS) begin
                state_n      = S_ADDR_ACK;
                phase_n      = 1'b0;
                rw_n         = sda_q;
                busy_n       = 1'b1;
                tx_shift_n   = i_data[15:8];
                tx_lo_n      = i_data[7:0];
                tx_next_lo_n = 1'b1;
              end else begin
                state_n = S_IGNORE;
              end
            end
          end
        end

        // phase 0: waiting for the fall that starts the ACK; phase 1: ACK is being driven.
        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase) begin
              sda_low_n = 1'b1;
              phase_n   = 1'b1;
            end else begin
              phase_n = 1'b0;
              if (rw) begin
                state_n    = S_TX_BYTE;
                sda_low_n  = ~tx_shift[7];
                tx_shift_n = {tx_shift[6:0], 1'b0};
                bit_cnt_n  = 3'd1;
              end else begin
                state_n   = S_RX_BYTE;
                sda_low_n = 1'b0;
                bit_cnt_n = 3'd0;
              end
            end
          end
        end

        // phase 1 means all 8 bits are in and the ACK starts at the next fall.
        S_RX_BYTE: begin
          if (scl_fall && phase) begin
            state_n        = S_RX_ACK;
            phase_n        = 1'b0;
            sda_low_n      = 1'b1;
            opcode_n       = rx_shift;
            opcode_valid_n = 1'b1;
          end else if (scl_rise && !phase) begin
            rx_shift_n = {rx_shift[6:0], sda_q};
            bit_cnt_n  = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) phase_n = 1'b1;
          end
        end

        S_RX_ACK: begin
          if (scl_fall) begin
            state_n   = S_RX_BYTE;
            sda_low_n = 1'b0;
          end
        end

        S_TX_BYTE: begin
          if (scl_fall) begin
            sda_low_n  = ~tx_shift[7];
            tx_shift_n = {tx_shift[6:0], 1'b0};
            bit_cnt_n  = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state_n = S_TX_ACK;
              phase_n = 1'b0;
            end
          end
        end

        // Release after the LSB clock, then sample the master's ACK/NACK on the next rise.
        S_TX_ACK: begin
          if (scl_fall && !phase) begin
            sda_low_n = 1'b0;
            phase_n   = 1'b1;
          end else if (scl_rise && phase) begin
            phase_n = 1'b0;
            if (sda_q) begin
              read_done_n = 1'b1;
              state_n     = S_IGNORE;
            end else begin
              state_n   = S_TX_BYTE;
              bit_cnt_n = 3'd0;
              if (tx_next_lo) begin
                tx_shift_n   = tx_lo;
                tx_next_lo_n = 1'b0;
              end else begin
                tx_shift_n   = i_data[15:8];
                tx_lo_n      = i_data[7:0];
                tx_next_lo_n = 1'b1;
              end
            end
          end
        end

        S_IGNORE: sda_low_n = 1'b0;

        default: begin
          state_n   = S_IDLE;
          sda_low_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= S_IDLE;
      bit_cnt        <= 3'd0;
      phase          <= 1'b0;
      rw             <= 1'b0;
      rx_shift       <= 8'h00;
      tx_shift       <= 8'h00;
      tx_lo          <= 8'h00;
      tx_next_lo     <= 1'b0;
      sda_low        <= 1'b0;
      o_opcode       <= 8'h00;
      o_opcode_valid <= 1'b0;
      o_read_done    <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      state          <= state_n;
      bit_cnt        <= bit_cnt_n;
      phase          <= phase_n;
      rw             <= rw_n;
      rx_shift       <= rx_shift_n;
      tx_shift       <= tx_shift_n;
      tx_lo          <= tx_lo_n;
      tx_next_lo     <= tx_next_lo_n;
      sda_low        <= sda_low_n;
      o_opcode       <= opcode_n;
      o_opcode_valid <= opcode_valid_n;
      o_read_done    <= read_done_n;
      o_busy         <= busy_n;
    end
  end

endmodule

// File: tb/tb_bh1750_i2c_target.sv
// Bench for bh1750_i2c_target: bit-banged I2C master on a pulled-up bus plus a
// transaction-level model (address match, last opcode, alternating hi/lo read bytes).
`timescale 1ns/1ps
module tb_bh1750_i2c_target;

  localparam logic [6:0] ADDR = 7'b010_0011;
  localparam int Q = 8;  // i_clk cycles per quarter SCL period

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wire scl, sda;
  pullup (scl);
  pullup (sda);
  logic m_scl_low, m_sda_low;
  assign scl = m_scl_low ? 1'b0 : 1'bz;
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  logic [15:0] data;
  logic [7:0]  opcode;
  logic        opcode_valid, read_done, busy;

  bh1750_i2c_target #(.p_ADDRESS(ADDR), .p_SYNC(2)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .io_scl(scl),
    .io_sda(sda),
    .i_data(data),
    .o_opcode(opcode),
    .o_opcode_valid(opcode_valid),
    .o_read_done(read_done),
    .o_busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Event monitor sampled away from the active edge.
  int   valid_cnt = 0, done_cnt = 0, wide_cnt = 0, dut_low_cnt = 0, busy_cnt = 0;
  logic valid_d = 1'b0, done_d = 1'b0;
  always @(negedge clk) begin
    valid_d <= opcode_valid;
    done_d  <= read_done;
    if (opcode_valid && !valid_d) valid_cnt <= valid_cnt + 1;
    if (read_done && !done_d) done_cnt <= done_cnt + 1;
    if ((opcode_valid && valid_d) || (read_done && done_d)) wide_cnt <= wide_cnt + 1;
    if (!m_sda_low && sda === 1'b0) dut_low_cnt <= dut_low_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  // Model state: opcode the target should currently hold.
  logic [7:0] model_opcode;

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bus master ----------------
  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; wait_q();
    m_scl_low = 1'b0; wait_q();
    m_sda_low = 1'b1; wait_q();
    m_scl_low = 1'b1; wait_q();
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; wait_q();
    m_scl_low = 1'b0; wait_q();
    m_sda_low = 1'b0; wait_q();
  endtask

  task automatic bus_bit(input logic b, output logic s);
    m_sda_low = ~b;   wait_q();
    m_scl_low = 1'b0; wait_q();
    s = (sda === 1'b0) ? 1'b0 : 1'b1;
    wait_q();
    m_scl_low = 1'b1; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      b[i] = s;
    end
    bus_bit(~master_ack, s);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    m_scl_low = 1'b0;
    m_sda_low = 1'b0;
    data = 16'hA55A;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({opcode, opcode_valid, read_done, busy} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got opcode=%h valid=%b done=%b busy=%b, want all 0",
               opcode, opcode_valid, read_done, busy);
    end
    checks++;
    if (sda !== 1'b1 || scl !== 1'b1) begin
      errors++;
      $display("FAIL reset_bus: got scl=%b sda=%b, want both released (1)", scl, sda);
    end
    rst = 1'b0;
    model_opcode = 8'h00;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write();
    logic a0, a1;
    int v0 = valid_cnt, w0 = wide_cnt;
    bus_start();
    write_byte(8'h46, a0);
    write_byte(8'h10, a1);
    model_opcode = 8'h10;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b want 1", busy); end
    bus_stop();
    wait_q();
    checks++;
    if (a0 !== 1'b0 || a1 !== 1'b0) begin
      errors++; $display("FAIL write_acks: got addr=%b data=%b want 0 0", a0, a1);
    end
    checks++;
    if (opcode !== model_opcode) begin
      errors++; $display("FAIL write_opcode: got %h want %h", opcode, model_opcode);
    end
    checks++;
    if (valid_cnt - v0 != 1 || wide_cnt != w0) begin
      errors++; $display("FAIL write_valid_pulse: got %0d pulses (%0d wide) want 1 (0 wide)",
                         valid_cnt - v0, wide_cnt - w0);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop: got %b want 0", busy); end
  endtask

  task automatic test_read();
    logic s, ack;
    logic [7:0] b0, b1;
    logic [7:0] a = 8'h47;
    int d0 = done_cnt, w0 = wide_cnt;
    data = 16'hA55A;
    bus_start();
    for (int i = 7; i >= 1; i--) bus_bit(a[i], s);
    // Last address bit by hand to time the ACK drive against the SCL fall.
    m_sda_low = 1'b0; wait_q();
    m_scl_low = 1'b0; wait_q(); wait_q();
    m_scl_low = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (sda !== 1'b1) begin errors++; $display("FAIL ack_hold: got sda=%b at 3 clk want 1", sda); end
    @(negedge clk);
    checks++;
    if (sda !== 1'b0) begin errors++; $display("FAIL ack_latency: got sda=%b at 4 clk want 0", sda); end
    repeat (Q - 4) @(negedge clk);
    bus_bit(1'b1, ack);
    read_byte(1'b1, b0);
    read_byte(1'b0, b1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL read_busy: got %b want 1", busy); end
    bus_stop();
    wait_q();
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL read_addr_ack: got %b want 0", ack); end
    checks++;
    if ({b0, b1} !== 16'hA55A) begin
      errors++; $display("FAIL read_bytes: got %h %h want a5 5a", b0, b1);
    end
    checks++;
    if (done_cnt - d0 != 1 || wide_cnt != w0) begin
      errors++; $display("FAIL read_done_pulse: got %0d pulses (%0d wide) want 1 (0 wide)",
                         done_cnt - d0, wide_cnt - w0);
    end
  endtask

  task automatic test_mismatch();
    logic a0, a1;
    int l0 = dut_low_cnt, v0 = valid_cnt, d0 = done_cnt, b0 = busy_cnt;
    bus_start();
    write_byte(8'h48, a0);
    write_byte(8'h10, a1);
    bus_stop();
    wait_q();
    checks++;
    if (a0 !== 1'b1 || a1 !== 1'b1) begin
      errors++; $display("FAIL mismatch_acks: got %b %b want 1 1", a0, a1);
    end
    checks++;
    if (dut_low_cnt != l0) begin
      errors++; $display("FAIL mismatch_sda: target pulled SDA low %0d cycles, want 0", dut_low_cnt - l0);
    end
    checks++;
    if (valid_cnt != v0 || done_cnt != d0 || busy_cnt != b0) begin
      errors++; $display("FAIL mismatch_quiet: got valid=%0d done=%0d busy_cycles=%0d want 0 0 0",
                         valid_cnt - v0, done_cnt - d0, busy_cnt - b0);
    end
    checks++;
    if (opcode !== model_opcode) begin
      errors++; $display("FAIL mismatch_opcode: got %h want %h", opcode, model_opcode);
    end
  endtask

  task automatic test_repeated_start();
    logic a0, a1, a2;
    logic [7:0] b0, b1;
    logic [15:0] word = 16'($urandom);
    data = word;
    bus_start();
    write_byte(8'h46, a0);
    write_byte(8'h01, a1);
    model_opcode = 8'h01;
    bus_start();
    write_byte(8'h47, a2);
    read_byte(1'b1, b0);
    read_byte(1'b0, b1);
    bus_stop();
    wait_q();
    checks++;
    if ({a0, a1, a2} !== 3'b000) begin
      errors++; $display("FAIL rstart_acks: got %b want 000", {a0, a1, a2});
    end
    checks++;
    if (opcode !== model_opcode) begin
      errors++; $display("FAIL rstart_opcode: got %h want %h", opcode, model_opcode);
    end
    checks++;
    if ({b0, b1} !== word) begin
      errors++; $display("FAIL rstart_read: got %h%h want %h", b0, b1, word);
    end
  endtask

  task automatic test_reset_mid_read();
    logic s, ack, a0, a1;
    data = 16'hA55A;
    bus_start();
    write_byte(8'h47, ack);
    for (int i = 0; i < 3; i++) bus_bit(1'b1, s);
    // Target now drives bit 4 of 0xA5, which is 0.
    checks++;
    if (sda !== 1'b0) begin errors++; $display("FAIL midread_drive: got sda=%b want 0", sda); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (sda !== 1'b1) begin errors++; $display("FAIL midread_release: got sda=%b want 1", sda); end
    checks++;
    if ({opcode, opcode_valid, read_done, busy} !== 11'd0) begin
      errors++; $display("FAIL midread_outputs: got opcode=%h valid=%b done=%b busy=%b want 0",
                         opcode, opcode_valid, read_done, busy);
    end
    rst = 1'b0;
    model_opcode = 8'h00;
    bus_stop();
    wait_q();
    bus_start();
    write_byte(8'h46, a0);
    write_byte(8'h20, a1);
    model_opcode = 8'h20;
    bus_stop();
    wait_q();
    checks++;
    if (a0 !== 1'b0 || a1 !== 1'b0 || opcode !== model_opcode) begin
      errors++; $display("FAIL after_reset_write: got acks %b %b opcode %h want 0 0 %h",
                         a0, a1, opcode, model_opcode);
    end
  endtask

  task automatic test_data_change();
    logic s, ack;
    logic [7:0] b0, b1;
    data = 16'hA55A;
    bus_start();
    write_byte(8'h47, ack);
    for (int i = 7; i >= 0; i--) begin
      if (i == 3) data = 16'h1234;
      bus_bit(1'b1, s);
      b0[i] = s;
    end
    bus_bit(1'b0, s);
    read_byte(1'b0, b1);
    bus_stop();
    wait_q();
    checks++;
    if ({b0, b1} !== 16'hA55A) begin
      errors++; $display("FAIL data_change: got %h %h want a5 5a", b0, b1);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      logic        match, rw, ack;
      logic [6:0]  addr7;
      logic [7:0]  b;
      logic [15:0] word;
      int          n, v0, d0;
      logic [7:0]  exp_b;
      match = ($urandom_range(0, 3) != 0);
      addr7 = ADDR;
      if (!match) begin
        addr7 = 7'($urandom_range(0, 127));
        while (addr7 == ADDR) addr7 = 7'($urandom_range(0, 127));
      end
      rw   = 1'($urandom_range(0, 1));
      word = 16'($urandom);
      data = word;
      n    = rw ? int'($urandom_range(1, 4)) : int'($urandom_range(0, 3));
      v0   = valid_cnt;
      d0   = done_cnt;
      bus_start();
      write_byte({addr7, rw}, ack);
      checks++;
      if (ack !== !match) begin
        errors++; $display("FAIL rand%0d_addr_ack: addr=%h got %b want %b", t, addr7, ack, !match);
      end
      for (int k = 0; k < n; k++) begin
        if (rw) begin
          read_byte(k != n - 1, b);
          exp_b = !match ? 8'hFF : ((k % 2 == 0) ? word[15:8] : word[7:0]);
          checks++;
          if (b !== exp_b) begin
            errors++; $display("FAIL rand%0d_byte%0d: got %h want %h", t, k, b, exp_b);
          end
        end else begin
          b = 8'($urandom);
          write_byte(b, ack);
          if (match) model_opcode = b;
          checks++;
          if (ack !== !match) begin
            errors++; $display("FAIL rand%0d_data_ack%0d: got %b want %b", t, k, ack, !match);
          end
        end
      end
      bus_stop();
      wait_q();
      checks++;
      if (opcode !== model_opcode || busy !== 1'b0) begin
        errors++; $display("FAIL rand%0d_state: got opcode %h busy %b want %h 0", t, opcode, busy, model_opcode);
      end
      checks++;
      if (valid_cnt - v0 != ((match && !rw) ? n : 0) || done_cnt - d0 != ((match && rw) ? 1 : 0)) begin
        errors++; $display("FAIL rand%0d_pulses: got valid=%0d done=%0d want %0d %0d", t,
                           valid_cnt - v0, done_cnt - d0, (match && !rw) ? n : 0, (match && rw) ? 1 : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_repeated_start();
    test_reset_mid_read();
    test_data_change();
    test_random();
    checks++;
    if (wide_cnt != 0) begin
      errors++; $display("FAIL pulse_width: %0d pulses longer than one cycle, want 0", wide_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
